bp_be_regfile_mw: RTL and testbench

Flop-based, multi-write-port RISC-V register file for wide-issue BE configurations, with parametrised read port count and register count. Keeps sync-read semantics: a read issues in cycle N, data is valid in N+1 and held until the next read on that port. Held data tracks later writes to the held address. An optional busy scoreboard marks registers reserved by in-flight instructions.

---
 rtl/bp_be_regfile_mw.sv | 114 +++++++++++
 tb/tb_bp_be_regfile_mw.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bp_be_regfile_mw.sv
// Flop-based multi-write-port register file with held sync-read ports.
// Optional busy scoreboard enabled by BP_BE_REGFILE_SCOREBOARD_EN.
module bp_be_regfile_mw #(
    parameter int data_width_p  = 64,
    parameter int els_p         = 32,
    parameter int read_ports_p  = 3,
    parameter int write_ports_p = 2,
    parameter int zero_x0_p     = 1,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [read_ports_p-1:0]                rs_r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0]  rs_addr_i,
    output logic [read_ports_p*data_width_p-1:0]   rs_data_o,
    output logic [read_ports_p-1:0]                rs_busy_o,
    input  logic [write_ports_p-1:0]               rd_w_v_i,
    input  logic [write_ports_p*addr_width_lp-1:0] rd_addr_i,
    input  logic [write_ports_p*data_width_p-1:0]  rd_data_i,
    input  logic                                   rsv_v_i,
    input  logic [addr_width_lp-1:0]               rsv_addr_i
);

    logic [data_width_p-1:0]  regs_q [els_p];
    logic [data_width_p-1:0]  regs_n [els_p];
    logic [addr_width_lp-1:0] held_addr_q [read_ports_p];
    logic [data_width_p-1:0]  held_data_q [read_ports_p];
    logic [addr_width_lp-1:0] sel_addr [read_ports_p];

    // Array as it will look after this edge; held ports sample it for bypass.
    always_comb begin
        regs_n = regs_q;
        for (int w = 0; w < write_ports_p; w++) begin
            if (rd_w_v_i[w]) begin
                regs_n[rd_addr_i[w*addr_width_lp +: addr_width_lp]] =
                    rd_data_i[w*data_width_p +: data_width_p];
            end
        end
        if (zero_x0_p != 0) begin
            regs_n[0] = '0;
        end
    end

    // A held port keeps re-sampling its own address, so it tracks writes.
    always_comb begin
        for (int r = 0; r < read_ports_p; r++) begin
            sel_addr[r] = rs_r_v_i[r]
                ? rs_addr_i[r*addr_width_lp +: addr_width_lp]
                : held_addr_q[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                regs_q[i] <= '0;
            end
            for (int r = 0; r < read_ports_p; r++) begin
                held_addr_q[r] <= '0;
                held_data_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_n;
            for (int r = 0; r < read_ports_p; r++) begin
                held_addr_q[r] <= sel_addr[r];
                held_data_q[r] <= regs_n[sel_addr[r]];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < read_ports_p; r++) begin
            rs_data_o[r*data_width_p +: data_width_p] = held_data_q[r];
        end
    end

`ifdef BP_BE_REGFILE_SCOREBOARD_EN
    logic [els_p-1:0]        busy_q;
    logic [els_p-1:0]        busy_n;
    logic [read_ports_p-1:0] held_busy_q;

    // Reserve is applied after clears: it belongs to a younger instruction.
    always_comb begin
        busy_n = busy_q;
        for (int w = 0; w < write_ports_p; w++) begin
            if (rd_w_v_i[w]) begin
                busy_n[rd_addr_i[w*addr_width_lp +: addr_width_lp]] = 1'b0;
            end
        end
        if (rsv_v_i && !(zero_x0_p != 0 && rsv_addr_i == '0)) begin
            busy_n[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q      <= '0;
            held_busy_q <= '0;
        end else begin
            busy_q <= busy_n;
            for (int r = 0; r < read_ports_p; r++) begin
                held_busy_q[r] <= busy_n[sel_addr[r]];
            end
        end
    end

    assign rs_busy_o = held_busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_v_i, rsv_addr_i};
    assign rs_busy_o  = '0;
`endif

endmodule

// File: tb/tb_bp_be_regfile_mw.sv
// Directed self-checking bench for bp_be_regfile_mw.
// Busy expectations follow BP_BE_REGFILE_SCOREBOARD_EN.
module tb_bp_be_regfile_mw;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int RP = 3;
    localparam int WP = 2;

`ifdef BP_BE_REGFILE_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [RP-1:0]  rs_r_v;
    logic [RP*AW-1:0] rs_addr;
    logic [RP*DW-1:0] rs_data;
    logic [RP*DW-1:0] rs_data_nz;
    logic [RP-1:0]  rs_busy;
    logic [RP-1:0]  rs_busy_nz;
    logic [WP-1:0]  rd_w_v;
    logic [WP*AW-1:0] rd_addr;
    logic [WP*DW-1:0] rd_data;
    logic           rsv_v;
    logic [AW-1:0]  rsv_addr;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bp_be_regfile_mw dut (
        .clk_i(clk), .reset_i(reset),
        .rs_r_v_i(rs_r_v), .rs_addr_i(rs_addr),
        .rs_data_o(rs_data), .rs_busy_o(rs_busy),
        .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
        .rsv_v_i(rsv_v), .rsv_addr_i(rsv_addr)
    );

    bp_be_regfile_mw #(.zero_x0_p(0)) dut_nz (
        .clk_i(clk), .reset_i(reset),
        .rs_r_v_i(rs_r_v), .rs_addr_i(rs_addr),
        .rs_data_o(rs_data_nz), .rs_busy_o(rs_busy_nz),
        .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
        .rsv_v_i(rsv_v), .rsv_addr_i(rsv_addr)
    );

    function automatic logic [DW-1:0] data(int r);
        return rs_data[r*DW +: DW];
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        reset    = 1'b0;
        rs_r_v   = '0;
        rs_addr  = '0;
        rd_w_v   = '0;
        rd_addr  = '0;
        rd_data  = '0;
        rsv_v    = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic rd(int r, int a);
        rs_r_v[r] = 1'b1;
        rs_addr[r*AW +: AW] = AW'(a);
    endtask

    task automatic wr(int w, int a, logic [DW-1:0] d);
        rd_w_v[w] = 1'b1;
        rd_addr[w*AW +: AW] = AW'(a);
        rd_data[w*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        chk("rst_d0", data(0), 0);
        chk("rst_d1", data(1), 0);
        chk("rst_d2", data(2), 0);
        chk("rst_busy", DW'(rs_busy), 0);

        // 1: read before write, write, read after; port1 tracks held x5
        rd(1, 5);
        step();
        chk("t1_pre", data(1), 0);
        wr(0, 5, 64'hA);
        step();
        chk("t1_hold", data(1), 64'hA);
        rd(0, 5);
        step();
        chk("t1_read", data(0), 64'hA);

        // 2: same-address writes, higher port wins, with bypass
        wr(0, 7, 64'h11);
        wr(1, 7, 64'h22);
        rd(2, 7);
        step();
        chk("t2_byp", data(2), 64'h22);
        rd(0, 7);
        step();
        chk("t2_reread", data(0), 64'h22);

        // 3: hold x3 and observe a write during the hold
        wr(0, 3, 64'h1);
        step();
        rd(1, 3);
        step();
        chk("t3_h0", data(1), 64'h1);
        wr(1, 3, 64'h99);
        step();
        chk("t3_h1", data(1), 64'h99);
        step();
        chk("t3_h2", data(1), 64'h99);

        // new read wins over a write to the old held address
        rd(0, 3);
        wr(0, 7, 64'h33);
        step();
        chk("t3_rdwin", data(0), 64'h99);
        rd(2, 7);
        step();
        chk("t3_arr", data(2), 64'h33);

        // 4: x0 hardwired vs. ordinary register
        wr(0, 0, 64'hFF);
        rd(0, 0);
        rd(1, 0);
        rd(2, 0);
        step();
        chk("t4_x0_p0", data(0), 0);
        chk("t4_x0_p1", data(1), 0);
        chk("t4_x0_p2", data(2), 0);
        chk("t4_nz", rs_data_nz[DW-1:0], 64'hFF);

        // 5: scoreboard
        rsv_v = 1'b1;
        rsv_addr = 5'd9;
        step();
        rd(0, 9);
        step();
        chk("t5_busy", DW'(rs_busy[0]), DW'(SB));
        wr(0, 9, 64'h5);
        step();
        chk("t5_clr", DW'(rs_busy[0]), 0);
        chk("t5_data", data(0), 64'h5);
        rsv_v = 1'b1;
        rsv_addr = 5'd9;
        wr(1, 9, 64'h6);
        step();
        chk("t5_setwin", DW'(rs_busy[0]), DW'(SB));
        chk("t5_data2", data(0), 64'h6);
        rsv_v = 1'b1;
        rsv_addr = 5'd0;
        rd(1, 0);
        step();
        chk("t5_rsv_x0", DW'(rs_busy[1]), 0);

        // 6: reset mid-hold with pending write and reserve
        rd(2, 12);
        step();
        wr(0, 12, 64'h77);
        rsv_v = 1'b1;
        rsv_addr = 5'd12;
        reset = 1'b1;
        step();
        chk("t6_d0", data(0), 0);
        chk("t6_d1", data(1), 0);
        chk("t6_d2", data(2), 0);
        chk("t6_busy", DW'(rs_busy), 0);
        rd(0, 12);
        rd(1, 5);
        step();
        chk("t6_x12", data(0), 0);
        chk("t6_x5", data(1), 0);
        chk("t6_busy12", DW'(rs_busy[0]), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
